// File: rtl/seg_xlat_stage.sv
// seg_xlat_stage
//
// Registered MIPS fixed-mapping translation stage. Each of NUM_CH channels
// turns a virtual address into a physical address plus a cached attribute.
// It also flags user-mode accesses to the kernel half of the address space.
// The stage sits between the core's address outputs and the cache's
// physical-address inputs.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds valid and its payload until that edge. Ready may be
// high while valid is low. Once out_valid is high, the payload stays stable
// and out_valid stays high until the transfer completes, a flush or a reset.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   kseg0_cached       cached attribute for kseg0 (Config.K0 == 3)
//   kuseg_cached       cached attribute for kuseg
//   k23_cached         cached attribute for kseg2/kseg3
//   in_valid/in_ready  per-channel request handshake
//   in_vaddr           virtual address, channel c at [32c+31:32c]
//   in_user            request issued in user mode
//   flush              drop every entry the channel holds
//   out_valid/out_ready per-channel result handshake
//   out_paddr          physical address, channel c at [32c+31:32c]
//   out_cached         cacheable attribute
//   out_addr_err       user-mode access to vaddr[31] = 1
module seg_xlat_stage #(
    parameter int unsigned NUM_CH        = 2,
    parameter bit          SKID          = 1'b1,
    parameter logic [31:0] USEG_OFFSET   = 32'h4000_0000,
    parameter logic [31:0] KSEG23_OFFSET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 kseg0_cached,
    input  logic                 kuseg_cached,
    input  logic                 k23_cached,
    input  logic [NUM_CH-1:0]    in_valid,
    output logic [NUM_CH-1:0]    in_ready,
    input  logic [32*NUM_CH-1:0] in_vaddr,
    input  logic [NUM_CH-1:0]    in_user,
    input  logic [NUM_CH-1:0]    flush,
    output logic [NUM_CH-1:0]    out_valid,
    input  logic [NUM_CH-1:0]    out_ready,
    output logic [32*NUM_CH-1:0] out_paddr,
    output logic [NUM_CH-1:0]    out_cached,
    output logic [NUM_CH-1:0]    out_addr_err
);

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [31:0] va;
            logic [31:0] xl_paddr;
            logic        xl_cached;
            logic        xl_err;
            logic        accept;
            logic        advance;

            logic        out_valid_q,  out_valid_d;
            logic [31:0] out_paddr_q,  out_paddr_d;
            logic        out_cached_q, out_cached_d;
            logic        out_err_q,    out_err_d;

            assign va = in_vaddr[32*c +: 32];

            // Fixed segment map. kseg0/kseg1 default to the 29-bit unmapped window.
            always_comb begin
                xl_paddr  = {3'b000, va[28:0]};
                xl_cached = 1'b0;
                if (!va[31]) begin
                    xl_paddr  = va + USEG_OFFSET;
                    xl_cached = kuseg_cached;
                end else if (va[30:29] == 2'b00) begin
                    xl_cached = kseg0_cached;
                end else if (va[30:29] == 2'b01) begin
                    xl_cached = 1'b0;
                end else begin
                    xl_paddr  = va + KSEG23_OFFSET;
                    xl_cached = k23_cached;
                end
                // A faulting access must never be treated as cacheable.
                // The address is still reported so the fault handler can inspect it.
                xl_err = in_user[c] & va[31];
                if (xl_err) begin
                    xl_cached = 1'b0;
                end
            end

            // The output register can take a new entry when it is empty or is being drained.
            assign advance = !out_valid_q | out_ready[c];

            if (SKID) begin : g_skid
                logic        skid_valid_q,  skid_valid_d;
                logic [31:0] skid_paddr_q,  skid_paddr_d;
                logic        skid_cached_q, skid_cached_d;
                logic        skid_err_q,    skid_err_d;

                // in_ready comes straight from a flop, which breaks the
                // combinational path from out_ready back to in_ready.
                assign in_ready[c] = !reset & !skid_valid_q;
                assign accept      = in_valid[c] & in_ready[c] & !flush[c];

                always_comb begin
                    out_valid_d   = out_valid_q;
                    out_paddr_d   = out_paddr_q;
                    out_cached_d  = out_cached_q;
                    out_err_d     = out_err_q;
                    skid_valid_d  = skid_valid_q;
                    skid_paddr_d  = skid_paddr_q;
                    skid_cached_d = skid_cached_q;
                    skid_err_d    = skid_err_q;
                    if (flush[c]) begin
                        out_valid_d  = 1'b0;
                        skid_valid_d = 1'b0;
                    end else if (advance) begin
                        // The skid entry is older than any new request, so it
                        // moves to the output first. accept cannot be high
                        // here while the skid entry is held.
                        out_valid_d  = skid_valid_q | accept;
                        skid_valid_d = 1'b0;
                        if (skid_valid_q) begin
                            out_paddr_d  = skid_paddr_q;
                            out_cached_d = skid_cached_q;
                            out_err_d    = skid_err_q;
                        end else if (accept) begin
                            out_paddr_d  = xl_paddr;
                            out_cached_d = xl_cached;
                            out_err_d    = xl_err;
                        end
                    end else if (accept) begin
                        skid_valid_d  = 1'b1;
                        skid_paddr_d  = xl_paddr;
                        skid_cached_d = xl_cached;
                        skid_err_d    = xl_err;
                    end
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        skid_valid_q  <= 1'b0;
                        skid_paddr_q  <= 32'h0;
                        skid_cached_q <= 1'b0;
                        skid_err_q    <= 1'b0;
                    end else begin
                        skid_valid_q  <= skid_valid_d;
                        skid_paddr_q  <= skid_paddr_d;
                        skid_cached_q <= skid_cached_d;
                        skid_err_q    <= skid_err_d;
                    end
                end
            end else begin : g_direct
                assign in_ready[c] = !reset & advance;
                assign accept      = in_valid[c] & in_ready[c] & !flush[c];

                always_comb begin
                    out_valid_d  = out_valid_q;
                    out_paddr_d  = out_paddr_q;
                    out_cached_d = out_cached_q;
                    out_err_d    = out_err_q;
                    if (flush[c]) begin
                        out_valid_d = 1'b0;
                    end else if (advance) begin
                        out_valid_d = accept;
                        if (accept) begin
                            out_paddr_d  = xl_paddr;
                            out_cached_d = xl_cached;
                            out_err_d    = xl_err;
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid_q  <= 1'b0;
                    out_paddr_q  <= 32'h0;
                    out_cached_q <= 1'b0;
                    out_err_q    <= 1'b0;
                end else begin
                    out_valid_q  <= out_valid_d;
                    out_paddr_q  <= out_paddr_d;
                    out_cached_q <= out_cached_d;
                    out_err_q    <= out_err_d;
                end
            end

            assign out_valid[c]         = out_valid_q;
            assign out_paddr[32*c +: 32] = out_paddr_q;
            assign out_cached[c]        = out_cached_q;
            assign out_addr_err[c]      = out_err_q;
        end
    endgenerate

endmodule

// File: tb/tb_seg_xlat_stage.sv
// Bench for seg_xlat_stage. Two instances share all inputs:
//   dut index 0: SKID=1, KSEG23_OFFSET=0
//   dut index 1: SKID=0, KSEG23_OFFSET=0x4000_0000 (exercises the kseg2/3 wrap)
// Each instance is checked every cycle against a queue model of its own.
module tb_seg_xlat_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        k0c, kuc, k23c;
    logic [1:0]  in_valid, in_user, flush, out_ready;
    logic [63:0] in_vaddr;

    logic [1:0]  in_ready_w   [2];
    logic [1:0]  out_valid_w  [2];
    logic [63:0] out_paddr_w  [2];
    logic [1:0]  out_cached_w [2];
    logic [1:0]  out_err_w    [2];

    seg_xlat_stage #(
        .NUM_CH(2), .SKID(1'b1), .USEG_OFFSET(32'h4000_0000), .KSEG23_OFFSET(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(rst), .kseg0_cached(k0c), .kuseg_cached(kuc), .k23_cached(k23c),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_vaddr(in_vaddr), .in_user(in_user),
        .flush(flush), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_paddr(out_paddr_w[0]), .out_cached(out_cached_w[0]), .out_addr_err(out_err_w[0])
    );

    seg_xlat_stage #(
        .NUM_CH(2), .SKID(1'b0), .USEG_OFFSET(32'h4000_0000), .KSEG23_OFFSET(32'h4000_0000)
    ) dut_k23 (
        .clk(clk), .reset(rst), .kseg0_cached(k0c), .kuseg_cached(kuc), .k23_cached(k23c),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_vaddr(in_vaddr), .in_user(in_user),
        .flush(flush), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_paddr(out_paddr_w[1]), .out_cached(out_cached_w[1]), .out_addr_err(out_err_w[1])
    );

    // Model entries hold {err, cached, paddr}. The queue index is dut*2 + channel.
    logic [33:0] exp_q [4][$];
    int n_cmp;
    int n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Segment map written as address ranges.
    function automatic logic [33:0] xlat(input logic [31:0] va, input logic user,
                                         input logic [31:0] k23off);
        logic [31:0] pa;
        logic        cch;
        logic        err;
        if (va < 32'h8000_0000) begin
            pa  = va + 32'h4000_0000;
            cch = kuc;
        end else if (va < 32'hA000_0000) begin
            pa  = va - 32'h8000_0000;
            cch = k0c;
        end else if (va < 32'hC000_0000) begin
            pa  = va - 32'hA000_0000;
            cch = 1'b0;
        end else begin
            pa  = va + k23off;
            cch = k23c;
        end
        err = user && (va >= 32'h8000_0000);
        if (err) cch = 1'b0;
        return {err, cch, pa};
    endfunction

    // dut 0 holds up to two entries and takes a new one while it holds fewer than two.
    // dut 1 holds one entry and takes a new one when empty or while it drains.
    function automatic logic pred_ready(input int d, input int c);
        int k;
        k = d * 2 + c;
        if (rst) return 1'b0;
        if (d == 0) return exp_q[k].size() < 2;
        return (exp_q[k].size() == 0) || out_ready[c];
    endfunction

    task automatic check_model();
        int k;
        logic [33:0] e;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                k = d * 2 + c;
                chk($sformatf("d%0d c%0d in_ready", d, c), 64'(in_ready_w[d][c]), 64'(pred_ready(d, c)));
                chk($sformatf("d%0d c%0d out_valid", d, c), 64'(out_valid_w[d][c]), 64'(exp_q[k].size() > 0));
                if (exp_q[k].size() > 0) begin
                    e = exp_q[k][0];
                    chk($sformatf("d%0d c%0d paddr", d, c), 64'(out_paddr_w[d][32*c +: 32]), 64'(e[31:0]));
                    chk($sformatf("d%0d c%0d cached", d, c), 64'(out_cached_w[d][c]), 64'(e[32]));
                    chk($sformatf("d%0d c%0d addr_err", d, c), 64'(out_err_w[d][c]), 64'(e[33]));
                end
            end
        end
    endtask

    task automatic model_update();
        int k;
        logic rdy;
        logic acc;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                k   = d * 2 + c;
                rdy = pred_ready(d, c);
                acc = in_valid[c] & rdy & !flush[c];
                if (exp_q[k].size() > 0 && out_ready[c]) void'(exp_q[k].pop_front());
                if (flush[c]) exp_q[k].delete();
                if (acc) exp_q[k].push_back(xlat(in_vaddr[32*c +: 32], in_user[c],
                                                 (d == 0) ? 32'h0000_0000 : 32'h4000_0000));
            end
        end
    endtask

    // Inputs are driven just after a negedge. One call covers one rising edge.
    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
    endtask

    task automatic check_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d in_ready", tag, d), 64'(in_ready_w[d]), 64'(2'b00));
            chk($sformatf("%s d%0d out_valid", tag, d), 64'(out_valid_w[d]), 64'(2'b00));
            chk($sformatf("%s d%0d out_paddr", tag, d), out_paddr_w[d], 64'h0);
            chk($sformatf("%s d%0d out_cached", tag, d), 64'(out_cached_w[d]), 64'(2'b00));
            chk($sformatf("%s d%0d addr_err", tag, d), 64'(out_err_w[d]), 64'(2'b00));
        end
    endtask

    typedef struct {
        logic [31:0] va0;
        logic [31:0] va1;
        logic [1:0]  user;
        logic        k0c;
        logic        kuc;
        logic        k23c;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p0_k23;  // channel 0 paddr from the instance with KSEG23_OFFSET = 0x4000_0000
        logic [1:0]  cached;
        logic [1:0]  err;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [31:0] rand_va();
        case ($urandom_range(0, 3))
            0:       return $urandom & 32'h7FFF_FFFF;
            1:       return 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
            2:       return 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
            default: return 32'hC000_0000 | ($urandom & 32'h3FFF_FFFF);
        endcase
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        //            va0            va1            user   k0c   kuc   k23c  p0             p1             p0_k23         cached err
        tbl[0] = '{32'h8000_1234, 32'hBFC0_0000, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h1FC0_0000, 32'h0000_1234, 2'b01, 2'b00};
        tbl[1] = '{32'h0000_0010, 32'hA000_0000, 2'b10, 1'b1, 1'b1, 1'b1, 32'h4000_0010, 32'h0000_0000, 32'h4000_0010, 2'b01, 2'b10};
        tbl[2] = '{32'hC000_0000, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 1'b1, 32'hC000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 2'b00};
        tbl[3] = '{32'h7FFF_FFFF, 32'hC000_0000, 2'b10, 1'b0, 1'b1, 1'b1, 32'hBFFF_FFFF, 32'hC000_0000, 32'hBFFF_FFFF, 2'b01, 2'b10};
        tbl[4] = '{32'h9FFF_FFFF, 32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b0, 32'h1FFF_FFFF, 32'h4000_0000, 32'h1FFF_FFFF, 2'b10, 2'b00};
        tbl[5] = '{32'h8000_1234, 32'h8000_1234, 2'b01, 1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_1234, 2'b10, 2'b01};

        // Reset
        rst = 1'b1;
        k0c = 1'b0; kuc = 1'b0; k23c = 1'b0;
        in_valid = 2'b00; in_user = 2'b00; flush = 2'b00; out_ready = 2'b11;
        in_vaddr = 64'h0;
        clear_model();
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // Table vectors: both channels issue together into empty stages
        for (int i = 0; i < 6; i++) begin
            in_vaddr  = {tbl[i].va1, tbl[i].va0};
            in_user   = tbl[i].user;
            k0c       = tbl[i].k0c;
            kuc       = tbl[i].kuc;
            k23c      = tbl[i].k23c;
            in_valid  = 2'b11;
            out_ready = 2'b11;
            cycle();
            in_valid = 2'b00;
            #1;
            chk($sformatf("tbl%0d valid", i), 64'(out_valid_w[0]), 64'(2'b11));
            chk($sformatf("tbl%0d paddr0", i), 64'(out_paddr_w[0][31:0]), 64'(tbl[i].p0));
            chk($sformatf("tbl%0d paddr1", i), 64'(out_paddr_w[0][63:32]), 64'(tbl[i].p1));
            chk($sformatf("tbl%0d cached", i), 64'(out_cached_w[0]), 64'(tbl[i].cached));
            chk($sformatf("tbl%0d addr_err", i), 64'(out_err_w[0]), 64'(tbl[i].err));
            chk($sformatf("tbl%0d k23 paddr0", i), 64'(out_paddr_w[1][31:0]), 64'(tbl[i].p0_k23));
            cycle();
        end

        // Stalled output fills the skid entry; held attributes ignore input changes; drains in order
        in_user = 2'b00; k0c = 1'b1; out_ready = 2'b00;
        in_valid = 2'b01; in_vaddr = {32'h0, 32'h8000_0000};
        cycle();
        in_vaddr = {32'h0, 32'h8000_0004};
        cycle();
        in_valid = 2'b00;
        #1;
        chk("skid in_ready low", 64'(in_ready_w[0][0]), 64'(1'b0));
        chk("skid head paddr", 64'(out_paddr_w[0][31:0]), 64'h0);
        k0c = 1'b0;
        cycle();
        chk("held cached", 64'(out_cached_w[0][0]), 64'(1'b1));
        out_ready = 2'b11;
        cycle();
        chk("skid second paddr", 64'(out_paddr_w[0][31:0]), 64'h4);
        chk("skid in_ready back", 64'(in_ready_w[0][0]), 64'(1'b1));
        cycle();
        chk("skid drained", 64'(out_valid_w[0][0]), 64'(1'b0));

        // Flush with output and skid both full while a request is offered
        out_ready = 2'b00; in_valid = 2'b01; in_vaddr = {32'h0, 32'h8000_0100};
        cycle();
        in_vaddr = {32'h0, 32'h8000_0200};
        cycle();
        flush = 2'b01;
        cycle();
        flush = 2'b00; in_valid = 2'b00;
        #1;
        chk("flush out_valid", 64'(out_valid_w[0][0]), 64'(1'b0));
        chk("flush in_ready", 64'(in_ready_w[0][0]), 64'(1'b1));
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = 2'($urandom_range(0, 3));
            out_ready = 2'($urandom_range(0, 3));
            flush[0]  = ($urandom_range(0, 15) == 0);
            flush[1]  = ($urandom_range(0, 15) == 0);
            in_user[0] = ($urandom_range(0, 3) == 0);
            in_user[1] = ($urandom_range(0, 3) == 0);
            k0c  = 1'($urandom_range(0, 1));
            kuc  = 1'($urandom_range(0, 1));
            k23c = 1'($urandom_range(0, 1));
            in_vaddr = {rand_va(), rand_va()};
            cycle();
        end

        // Reset asserted mid-stall clears outputs without waiting for a clock edge
        flush = 2'b00; in_user = 2'b00; out_ready = 2'b00; in_valid = 2'b11;
        in_vaddr = {32'hC000_0040, 32'h8000_0040};
        cycle();
        cycle();
        in_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("mid reset");
        clear_model();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 2'b11;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
